// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the RV32 instruction-fetch stage.
//   fetch_state_t    : fetch controller states (RUN / WAIT / ERR)
//   fetch_entry_t    : one buffered fetch result {instr, pc}
//   NOP_INSTR        : canonical RV32 NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC : PC used when the top is not given RESET_PC
//   isWordAligned()  : true when an address has its two low bits clear
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic isWordAligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// Instruction-memory request/grant/response bus between the fetch stage
// (master) and instruction memory (slave).
//   imemReq    : master -> slave, fetch request
//   imemAddr   : master -> slave, word address of the request
//   imemGnt    : slave -> master, request accepted when imemReq & imemGnt
//   imemRvalid : slave -> master, response valid (in order, after grant)
//   imemRdata  : slave -> master, returned instruction word
// ---------------------------------------------------------------------------
interface fetch_if;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemGnt,
        input  imemRvalid,
        input  imemRdata
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemGnt,
        output imemRvalid,
        output imemRdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Circular buffer of DEPTH {instr, pc} entries between the fetch controller
// and the decode stage. DEPTH must be a power of two so the pointers wrap
// naturally.
//   clk, reset : clock, asynchronous active-low reset
//   push       : write pushData at the tail
//   pushData   : entry to write
//   pop        : retire the head entry
//   flush      : empty the buffer; wins over push and pop
//   count      : number of valid entries (0..DEPTH)
//   headData   : entry at the head (meaningful only when count != 0)
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               pushData,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output fetch_entry_t               headData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    // Guard against overflow/underflow so a misbehaving caller cannot
    // corrupt the pointers; flush overrides everything.
    always_comb begin
        doPush = push && !flush && (count < CNT_DEPTH);
        doPop  = pop && !flush && (count != '0);
    end

    // Pointer and occupancy bookkeeping. Pointers are PW bits wide, so
    // incrementing past DEPTH-1 wraps back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            entries[wrPtr] <= pushData;
        end
    end

    assign headData = entries[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// RV32 instruction-fetch stage. Owns the PC, issues one word fetch at a
// time to instruction memory, buffers returned instructions with their PCs
// in fetch_fifo and hands them to decode over a valid/ready handshake.
// Redirects from execute flush the buffer and discard stale responses.
//   clk, reset : clock, asynchronous active-low reset
//   imem       : instruction-memory bus (fetch_if master modport)
//   redirect   : taken branch/jump from execute
//   PCTarget   : new PC, sampled when redirect is high
//   validD     : head of the buffer is valid for decode
//   readyD     : decode accepts the head
//   InstrD     : head instruction (NOP when nothing is valid)
//   PCD        : head PC (RESET_PC when nothing is valid)
//   PCPlus4D   : PCD + 4, wrapping modulo 2^32
//   misalign   : sticky fault, redirect to a non-word-aligned target
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     imem,
    input  logic        redirect,
    input  logic [31:0] PCTarget,
    output logic        validD,
    input  logic        readyD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        misalign
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    fetch_state_t  state;
    fetch_state_t  stateNext;
    logic [31:0]   pc;
    logic [31:0]   pcNext;
    logic [31:0]   pcReq;
    logic [31:0]   pcReqNext;
    logic          drop;
    logic          dropNext;
    logic          misalignNext;
    logic          reqInt;
    logic          push;
    logic          pop;
    logic          flush;
    logic          targetAligned;
    logic [CW-1:0] count;
    fetch_entry_t  pushData;
    fetch_entry_t  headData;

    assign targetAligned = isWordAligned(PCTarget);

    // Controller state. The outstanding fetch lives in WAIT, so issuing only
    // from RUN with count < DEPTH guarantees a free slot for its response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            pcReq    <= RESET_PC;
            drop     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            pcReq    <= pcReqNext;
            drop     <= dropNext;
            misalign <= misalignNext;
        end
    end

    // Next-state, request and buffer-control logic. A redirect outranks
    // everything: it withdraws an ungranted request, so a grant can never
    // coincide with a redirect, and the only stale fetch to discard is one
    // already outstanding in WAIT.
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        pcReqNext    = pcReq;
        dropNext     = drop;
        misalignNext = misalign;
        reqInt       = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;

        // Reset gates the request combinationally so it is low while reset
        // is held and rises in the very first cycle after release.
        reqInt = reset && (state == RUN) && !redirect && (count < CNT_DEPTH);
        flush  = redirect && (state != ERR);

        case (state)
            RUN: begin
                if (redirect) begin
                    if (!targetAligned) begin
                        stateNext    = ERR;
                        misalignNext = 1'b1;
                    end else begin
                        pcNext = PCTarget;
                    end
                end else if (reqInt && imem.imemGnt) begin
                    stateNext = WAIT;
                    pcReqNext = pc;
                    pcNext    = pc + 32'd4;
                end
            end

            WAIT: begin
                if (redirect) begin
                    if (!targetAligned) begin
                        stateNext    = ERR;
                        misalignNext = 1'b1;
                        dropNext     = 1'b0;
                    end else begin
                        pcNext = PCTarget;
                        // A response landing in the redirect cycle is stale
                        // and retires the outstanding fetch; otherwise mark
                        // the still-pending response for discard.
                        if (imem.imemRvalid) begin
                            stateNext = RUN;
                            dropNext  = 1'b0;
                        end else begin
                            dropNext  = 1'b1;
                        end
                    end
                end else if (imem.imemRvalid) begin
                    push      = !drop;
                    dropNext  = 1'b0;
                    stateNext = RUN;
                end
            end

            ERR: begin
                stateNext = ERR;
            end

            default: begin
                stateNext = ERR;
            end
        endcase
    end

    assign imem.imemReq  = reqInt;
    assign imem.imemAddr = pc;

    assign pushData = {imem.imemRdata, pcReq};
    assign validD   = (count != '0) && (state != ERR);
    assign pop      = validD && readyD && !flush;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (pushData),
        .pop      (pop),
        .flush    (flush),
        .count    (count),
        .headData (headData)
    );

    // Decode sees a NOP at RESET_PC whenever the buffer head is not valid.
    always_comb begin
        if (validD) begin
            InstrD = headData.instr;
            PCD    = headData.pc;
        end else begin
            InstrD = NOP_INSTR;
            PCD    = RESET_PC;
        end
        PCPlus4D = PCD + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural instruction memory
// answers requests with configurable grant and response delays; expected
// decode outputs are queued by the stimulus and checked by a monitor each
// time decode accepts an entry.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic        validD;
    logic        readyD = 1'b0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    exp_t expQ[$];
    int   popCount = 0;

    // Memory model state
    int          gntDelay = 0;
    int          respDelay = 1;
    int          waitCnt = 0;
    int          timer = 0;
    int          grantCount = 0;
    logic        pending = 1'b0;
    logic [31:0] respAddr = 32'h0;
    logic        prevStall = 1'b0;
    logic [31:0] stallAddr = 32'h0;

    fetch_if imem();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imem),
        .redirect (redirect),
        .PCTarget (PCTarget),
        .validD   (validD),
        .readyD   (readyD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ addr;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive decode-side and redirect inputs; called at a falling edge.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] target);
        readyD   = rdy;
        redirect = redir;
        PCTarget = target;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] plus4);
        exp_t e;
        e.pc    = pc;
        e.plus4 = plus4;
        expQ.push_back(e);
    endtask

    // Assert reset for two cycles; leaves reset asserted.
    task automatic applyReset(input logic clearMem);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        expQ.delete();
        popCount   = 0;
        grantCount = 0;
        if (clearMem) begin
            pending   = 1'b0;
            timer     = 0;
            waitCnt   = 0;
            prevStall = 1'b0;
            gntDelay  = 0;
            respDelay = 1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic waitPops(input int n, input int budget);
        int k = 0;
        while (popCount < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        readyD = 1'b0;
        checkOutput("popCount", 32'(popCount), 32'(n));
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    endtask

    task automatic waitGrant(input logic [31:0] addr, input int budget);
        int k = 0;
        while (!(pending && respAddr == addr) && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("grantSeen", {31'd0, (pending && respAddr == addr)}, 32'd1);
    endtask

    // Instruction memory: decides grant and response in mid-cycle, then
    // samples the handshake just before the rising edge.
    initial begin : memModel
        imem.imemGnt    = 1'b0;
        imem.imemRvalid = 1'b0;
        imem.imemRdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            imem.imemRvalid = 1'b0;
            if (pending) begin
                timer--;
                if (timer <= 0) begin
                    imem.imemRvalid = 1'b1;
                    imem.imemRdata  = memWord(respAddr);
                    pending         = 1'b0;
                end
            end
            imem.imemGnt = imem.imemReq && !pending && (waitCnt >= gntDelay);
            #3;
            if (prevStall && imem.imemReq) begin
                checkOutput("addrStable", imem.imemAddr, stallAddr);
            end
            if (imem.imemReq && imem.imemGnt) begin
                pending   = 1'b1;
                timer     = respDelay;
                respAddr  = imem.imemAddr;
                grantCount++;
                waitCnt   = 0;
                prevStall = 1'b0;
            end else if (imem.imemReq) begin
                waitCnt++;
                prevStall = 1'b1;
                stallAddr = imem.imemAddr;
            end else begin
                waitCnt   = 0;
                prevStall = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every accepted decode handshake pops one entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (reset && !redirect && validD && readyD) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedOutput: actual PCD=%h expected no output at %0t", PCD, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("PCD", PCD, e.pc);
                    checkOutput("InstrD", InstrD, memWord(e.pc));
                    checkOutput("PCPlus4D", PCPlus4D, e.plus4);
                end
                popCount++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        int g;

        // Reset values and streaming with a single-cycle memory
        $display("[TB] test: reset and streaming");
        applyReset(1'b1);
        #2;
        checkOutput("rstReq", {31'd0, imem.imemReq}, 32'd0);
        checkOutput("rstValid", {31'd0, validD}, 32'd0);
        checkOutput("rstInstr", InstrD, 32'h0000_0013);
        checkOutput("rstPCD", PCD, 32'h0000_0000);
        checkOutput("rstPCPlus4", PCPlus4D, 32'h0000_0004);
        checkOutput("rstMisalign", {31'd0, misalign}, 32'd0);
        pushExp(32'h0, 32'h4);
        pushExp(32'h4, 32'h8);
        pushExp(32'h8, 32'hC);
        releaseReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("firstReq", {31'd0, imem.imemReq}, 32'd1);
        checkOutput("firstAddr", imem.imemAddr, 32'h0);
        waitPops(3, 40);

        // Backpressure: two buffered entries stop requests, drain in order
        $display("[TB] test: backpressure");
        applyReset(1'b1);
        releaseReset();
        repeat (10) @(negedge clk);
        #2;
        checkOutput("fullValid", {31'd0, validD}, 32'd1);
        checkOutput("fullNoReq", {31'd0, imem.imemReq}, 32'd0);
        checkOutput("fullGrants", 32'(grantCount), 32'd2);
        pushExp(32'h0, 32'h4);
        pushExp(32'h4, 32'h8);
        pushExp(32'h8, 32'hC);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitPops(3, 40);

        // Grant held off for three cycles
        $display("[TB] test: delayed grant");
        applyReset(1'b1);
        gntDelay = 3;
        pushExp(32'h0, 32'h4);
        releaseReset();
        #2;
        checkOutput("stallReq0", {31'd0, imem.imemReq}, 32'd1);
        checkOutput("stallAddr0", imem.imemAddr, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        checkOutput("stallReq2", {31'd0, imem.imemReq}, 32'd1);
        checkOutput("stallAddr2", imem.imemAddr, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitPops(1, 40);
        #2;
        checkOutput("singleGrant", 32'(grantCount), 32'd1);

        // Redirect while the fetch of 0x8 is outstanding
        $display("[TB] test: redirect with outstanding fetch");
        applyReset(1'b1);
        respDelay = 3;
        pushExp(32'h0, 32'h4);
        pushExp(32'h4, 32'h8);
        pushExp(32'h100, 32'h104);
        releaseReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitGrant(32'h8, 60);
        applyStimulus(1'b1, 1'b1, 32'h100);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("dropWaitReq", {31'd0, imem.imemReq}, 32'd0);
        waitPops(3, 60);

        // Misaligned redirect halts the unit until reset
        $display("[TB] test: misaligned redirect");
        applyReset(1'b1);
        releaseReset();
        repeat (8) @(negedge clk);
        #2;
        checkOutput("preErrValid", {31'd0, validD}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h102);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("errMisalign", {31'd0, misalign}, 32'd1);
        checkOutput("errValid", {31'd0, validD}, 32'd0);
        checkOutput("errReq", {31'd0, imem.imemReq}, 32'd0);
        g = grantCount;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h200);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        #2;
        checkOutput("errStuckReq", {31'd0, imem.imemReq}, 32'd0);
        checkOutput("errStuckMisalign", {31'd0, misalign}, 32'd1);
        checkOutput("errStuckValid", {31'd0, validD}, 32'd0);
        checkOutput("errNoGrants", 32'(grantCount), 32'(g));
        applyReset(1'b1);
        #2;
        checkOutput("errCleared", {31'd0, misalign}, 32'd0);

        // Reset while a fetch is outstanding; its late response is ignored
        $display("[TB] test: reset during outstanding fetch");
        respDelay = 8;
        pushExp(32'h0, 32'h4);
        pushExp(32'h4, 32'h8);
        releaseReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitGrant(32'h8, 80);
        checkOutput("preResetDrain", 32'(expQ.size()), 32'd0);
        applyReset(1'b0);
        pushExp(32'h0, 32'h4);
        releaseReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitPops(1, 60);

        // PC wraps past the top of the address space
        $display("[TB] test: PC wrap");
        applyReset(1'b1);
        pushExp(32'hFFFF_FFFC, 32'h0000_0000);
        pushExp(32'h0000_0000, 32'h0000_0004);
        releaseReset();
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("wrapReq", {31'd0, imem.imemReq}, 32'd1);
        checkOutput("wrapAddr", imem.imemAddr, 32'hFFFF_FFFC);
        waitPops(2, 40);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
